broadcast_wakeup_station: RTL and testbench

- Reservation station sitting between rename and the dispatch/execute block.
- Holds renamed instructions whose operands may still be pending on producer tags, and snoops the result broadcast bus (tag + data) emitted by the dispatch/execute block to wake waiting operands.
- Issues ready instructions on the dispatch interface (dispatch, op1, op2, executionID, executionTag), gated by that block's per-FU idle vector.
- It is the consumer end of the broadcast protocol and the producer end of the dispatch protocol.

---
 rtl/broadcast_wakeup_station_pkg.sv | 38 +++
 rtl/broadcast_wakeup_station_entry.sv | 110 +++++++++++
 rtl/broadcast_wakeup_station.sv | 163 ++++++++++++++++
 tb/tb_broadcast_wakeup_station.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/broadcast_wakeup_station_pkg.sv
// Shared definitions for the reservation station and the dispatch/execute block:
// functional-unit IDs, default widths and the station entry record.
package broadcast_wakeup_station_pkg;

   localparam int unsigned RS_DATA_WIDTH = 32;
   localparam int unsigned RS_TAG_WIDTH  = 7;
   localparam int unsigned RS_EXEC_WIDTH = 4;
   localparam int unsigned RS_DEPTH_DEF  = 8;

   typedef enum logic [3:0] {
      FU_AND  = 4'd0,
      FU_OR   = 4'd1,
      FU_SRA  = 4'd2,
      FU_SRL  = 4'd3,
      FU_XOR  = 4'd4,
      FU_SLTU = 4'd5,
      FU_SLT  = 4'd6,
      FU_SLL  = 4'd7,
      FU_SUB  = 4'd8,
      FU_ADD  = 4'd9,
      FU_NOP  = 4'd15
   } fu_id_e;

   // Operand slot: value when ready, producer tag in the low bits otherwise.
   typedef struct packed {
      logic                     ready;
      logic [RS_DATA_WIDTH-1:0] value;
   } rs_operand_t;

   typedef struct packed {
      logic                    valid;
      fu_id_e                  executionID;
      logic [RS_TAG_WIDTH-1:0] executionTag;
      rs_operand_t             op1;
      rs_operand_t             op2;
   } rs_entry_t;

endpackage

// File: rtl/broadcast_wakeup_station_entry.sv
// One reservation-station entry: allocation write, per-operand broadcast
// snoop with allocate-bypass, and the combined operand-ready flag.
module rs_entry
   import broadcast_wakeup_station_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = RS_DATA_WIDTH,
   parameter int unsigned TAG_WIDTH  = RS_TAG_WIDTH,
   parameter int unsigned EXEC_WIDTH = RS_EXEC_WIDTH
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush_i,
   input  logic                  alloc_we_i,
   input  logic [EXEC_WIDTH-1:0] alloc_id_i,
   input  logic [TAG_WIDTH-1:0]  alloc_tag_i,
   input  logic                  alloc_op1_ready_i,
   input  logic [DATA_WIDTH-1:0] alloc_op1_i,
   input  logic                  alloc_op2_ready_i,
   input  logic [DATA_WIDTH-1:0] alloc_op2_i,
   input  logic                  issue_clr_i,
   input  logic                  bcast_valid_i,
   input  logic [TAG_WIDTH-1:0]  bcast_tag_i,
   input  logic [DATA_WIDTH-1:0] bcast_data_i,
   output logic                  valid_o,
   output logic                  ready_o,
   output logic [EXEC_WIDTH-1:0] id_o,
   output logic [TAG_WIDTH-1:0]  tag_o,
   output logic [DATA_WIDTH-1:0] op1_o,
   output logic [DATA_WIDTH-1:0] op2_o
);

   logic                  valid_q, valid_d;
   logic [EXEC_WIDTH-1:0] id_q, id_d;
   logic [TAG_WIDTH-1:0]  tag_q, tag_d;
   logic                  op1_rdy_q, op1_rdy_d;
   logic                  op2_rdy_q, op2_rdy_d;
   logic [DATA_WIDTH-1:0] op1_q, op1_d;
   logic [DATA_WIDTH-1:0] op2_q, op2_d;

   logic hit1_alloc, hit2_alloc, hit1_wake, hit2_wake;

   function automatic logic tag_hit(input logic rdy, input logic [DATA_WIDTH-1:0] slot,
                                    input logic bv, input logic [TAG_WIDTH-1:0] bt);
      return !rdy && bv && (slot[TAG_WIDTH-1:0] == bt);
   endfunction

   assign hit1_alloc = tag_hit(alloc_op1_ready_i, alloc_op1_i, bcast_valid_i, bcast_tag_i);
   assign hit2_alloc = tag_hit(alloc_op2_ready_i, alloc_op2_i, bcast_valid_i, bcast_tag_i);
   assign hit1_wake  = tag_hit(op1_rdy_q, op1_q, bcast_valid_i, bcast_tag_i);
   assign hit2_wake  = tag_hit(op2_rdy_q, op2_q, bcast_valid_i, bcast_tag_i);

   always_comb begin
      valid_d   = valid_q;
      id_d      = id_q;
      tag_d     = tag_q;
      op1_rdy_d = op1_rdy_q;
      op2_rdy_d = op2_rdy_q;
      op1_d     = op1_q;
      op2_d     = op2_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (alloc_we_i) begin
         valid_d   = 1'b1;
         id_d      = alloc_id_i;
         tag_d     = alloc_tag_i;
         op1_rdy_d = alloc_op1_ready_i | hit1_alloc;
         op2_rdy_d = alloc_op2_ready_i | hit2_alloc;
         op1_d     = hit1_alloc ? bcast_data_i : alloc_op1_i;
         op2_d     = hit2_alloc ? bcast_data_i : alloc_op2_i;
      end else if (valid_q) begin
         if (issue_clr_i) valid_d = 1'b0;
         if (hit1_wake) begin
            op1_rdy_d = 1'b1;
            op1_d     = bcast_data_i;
         end
         if (hit2_wake) begin
            op2_rdy_d = 1'b1;
            op2_d     = bcast_data_i;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q   <= 1'b0;
         id_q      <= '0;
         tag_q     <= '0;
         op1_rdy_q <= 1'b0;
         op2_rdy_q <= 1'b0;
         op1_q     <= '0;
         op2_q     <= '0;
      end else begin
         valid_q   <= valid_d;
         id_q      <= id_d;
         tag_q     <= tag_d;
         op1_rdy_q <= op1_rdy_d;
         op2_rdy_q <= op2_rdy_d;
         op1_q     <= op1_d;
         op2_q     <= op2_d;
      end
   end

   assign valid_o = valid_q;
   assign ready_o = op1_rdy_q & op2_rdy_q;
   assign id_o    = id_q;
   assign tag_o   = tag_q;
   assign op1_o   = op1_q;
   assign op2_o   = op2_q;

endmodule

// File: rtl/broadcast_wakeup_station.sv
// Reservation station top: free/eligible priority select, registered issue
// port, back-to-back same-FU mask and occupancy count over rs_entry slots.
module broadcast_wakeup_station
   import broadcast_wakeup_station_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = RS_DATA_WIDTH,
   parameter int unsigned TAG_WIDTH  = RS_TAG_WIDTH,
   parameter int unsigned EXEC_WIDTH = RS_EXEC_WIDTH,
   parameter int unsigned RS_DEPTH   = RS_DEPTH_DEF
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         alloc_valid,
   output logic                         alloc_ready,
   input  logic [EXEC_WIDTH-1:0]        alloc_executionID,
   input  logic [TAG_WIDTH-1:0]         alloc_executionTag,
   input  logic                         alloc_op1_ready,
   input  logic [DATA_WIDTH-1:0]        alloc_op1,
   input  logic                         alloc_op2_ready,
   input  logic [DATA_WIDTH-1:0]        alloc_op2,
   input  logic                         broadcastDataAvailable,
   input  logic [TAG_WIDTH-1:0]         broadcastDestinationTag,
   input  logic [DATA_WIDTH-1:0]        broadcastDestinationData,
   input  logic [(2**EXEC_WIDTH)-1:0]   availableFunctionalUnits,
   output logic                         dispatch,
   output logic [DATA_WIDTH-1:0]        op1,
   output logic [DATA_WIDTH-1:0]        op2,
   output logic [EXEC_WIDTH-1:0]        executionID,
   output logic [TAG_WIDTH-1:0]         executionTag,
   output logic [$clog2(RS_DEPTH):0]    occupancy
);

   localparam int unsigned OCC_W = $clog2(RS_DEPTH) + 1;
   localparam logic [RS_DEPTH-1:0]   LSB_ONE = RS_DEPTH'(1);
   localparam logic [EXEC_WIDTH-1:0] NOP_ID  = EXEC_WIDTH'(FU_NOP);

   logic [RS_DEPTH-1:0]   ent_valid, ent_ready;
   logic [RS_DEPTH-1:0]   free_vec, alloc_oh, alloc_we;
   logic [RS_DEPTH-1:0]   eligible, sel_oh, issue_clr;
   logic [EXEC_WIDTH-1:0] ent_id  [RS_DEPTH];
   logic [TAG_WIDTH-1:0]  ent_tag [RS_DEPTH];
   logic [DATA_WIDTH-1:0] ent_op1 [RS_DEPTH];
   logic [DATA_WIDTH-1:0] ent_op2 [RS_DEPTH];

   logic                  alloc_fire, issue_fire;
   logic [EXEC_WIDTH-1:0] sel_id;
   logic [TAG_WIDTH-1:0]  sel_tag;
   logic [DATA_WIDTH-1:0] sel_op1, sel_op2;

   logic                  dispatch_q, dispatch_d;
   logic [DATA_WIDTH-1:0] op1_q, op1_d, op2_q, op2_d;
   logic [EXEC_WIDTH-1:0] exec_id_q, exec_id_d;
   logic [TAG_WIDTH-1:0]  exec_tag_q, exec_tag_d;
   logic [OCC_W-1:0]      occ_q, occ_d;

   // Room depends only on registered valid bits; an issuing slot frees next cycle.
   assign free_vec    = ~ent_valid;
   assign alloc_ready = |free_vec;
   assign alloc_oh    = free_vec & (~free_vec + LSB_ONE);
   assign alloc_fire  = alloc_valid & alloc_ready & ~flush;
   assign alloc_we    = alloc_fire ? alloc_oh : '0;

   for (genvar g = 0; g < RS_DEPTH; g++) begin : g_entry
      rs_entry #(
         .DATA_WIDTH (DATA_WIDTH),
         .TAG_WIDTH  (TAG_WIDTH),
         .EXEC_WIDTH (EXEC_WIDTH)
      ) u_entry (
         .clk               (clk),
         .rst               (rst),
         .flush_i           (flush),
         .alloc_we_i        (alloc_we[g]),
         .alloc_id_i        (alloc_executionID),
         .alloc_tag_i       (alloc_executionTag),
         .alloc_op1_ready_i (alloc_op1_ready),
         .alloc_op1_i       (alloc_op1),
         .alloc_op2_ready_i (alloc_op2_ready),
         .alloc_op2_i       (alloc_op2),
         .issue_clr_i       (issue_clr[g]),
         .bcast_valid_i     (broadcastDataAvailable),
         .bcast_tag_i       (broadcastDestinationTag),
         .bcast_data_i      (broadcastDestinationData),
         .valid_o           (ent_valid[g]),
         .ready_o           (ent_ready[g]),
         .id_o              (ent_id[g]),
         .tag_o             (ent_tag[g]),
         .op1_o             (ent_op1[g]),
         .op2_o             (ent_op2[g])
      );
   end

   // The idle bit lags a dispatch by one cycle, so the FU just issued is masked;
   // NOP has no unit to occupy and is exempt.
   always_comb begin
      eligible = '0;
      for (int unsigned i = 0; i < RS_DEPTH; i++) begin
         eligible[i] = ent_valid[i] & ent_ready[i] & availableFunctionalUnits[ent_id[i]] &
                       ~(dispatch_q & (ent_id[i] == exec_id_q) & (ent_id[i] != NOP_ID));
      end
   end

   assign sel_oh     = eligible & (~eligible + LSB_ONE);
   assign issue_fire = (|eligible) & ~flush;
   assign issue_clr  = issue_fire ? sel_oh : '0;

   always_comb begin
      sel_id  = '0;
      sel_tag = '0;
      sel_op1 = '0;
      sel_op2 = '0;
      for (int unsigned i = 0; i < RS_DEPTH; i++) begin
         if (sel_oh[i]) begin
            sel_id  = sel_id  | ent_id[i];
            sel_tag = sel_tag | ent_tag[i];
            sel_op1 = sel_op1 | ent_op1[i];
            sel_op2 = sel_op2 | ent_op2[i];
         end
      end
   end

   always_comb begin
      dispatch_d = issue_fire;
      op1_d      = op1_q;
      op2_d      = op2_q;
      exec_id_d  = exec_id_q;
      exec_tag_d = exec_tag_q;
      if (issue_fire) begin
         op1_d      = sel_op1;
         op2_d      = sel_op2;
         exec_id_d  = sel_id;
         exec_tag_d = sel_tag;
      end
      if (flush) occ_d = '0;
      else       occ_d = occ_q + OCC_W'(alloc_fire) - OCC_W'(issue_fire);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dispatch_q <= 1'b0;
         op1_q      <= '0;
         op2_q      <= '0;
         exec_id_q  <= '0;
         exec_tag_q <= '0;
         occ_q      <= '0;
      end else begin
         dispatch_q <= dispatch_d;
         op1_q      <= op1_d;
         op2_q      <= op2_d;
         exec_id_q  <= exec_id_d;
         exec_tag_q <= exec_tag_d;
         occ_q      <= occ_d;
      end
   end

   assign dispatch     = dispatch_q;
   assign op1          = op1_q;
   assign op2          = op2_q;
   assign executionID  = exec_id_q;
   assign executionTag = exec_tag_q;
   assign occupancy    = occ_q;

endmodule

// File: tb/tb_broadcast_wakeup_station.sv
// Directed bench for broadcast_wakeup_station: issue payloads go through a
// scoreboard queue, timing and status are checked at fixed cycles.
module tb_broadcast_wakeup_station;
   import broadcast_wakeup_station_pkg::*;

   localparam int unsigned DW = 32;
   localparam int unsigned TW = 7;
   localparam int unsigned EW = 4;
   localparam int unsigned D  = 8;

   logic            clk = 1'b0;
   logic            rst, flush, alloc_valid, alloc_ready;
   logic [EW-1:0]   alloc_executionID;
   logic [TW-1:0]   alloc_executionTag;
   logic            alloc_op1_ready, alloc_op2_ready;
   logic [DW-1:0]   alloc_op1, alloc_op2;
   logic            broadcastDataAvailable;
   logic [TW-1:0]   broadcastDestinationTag;
   logic [DW-1:0]   broadcastDestinationData;
   logic [(2**EW)-1:0] availableFunctionalUnits;
   logic            dispatch;
   logic [DW-1:0]   op1, op2;
   logic [EW-1:0]   executionID;
   logic [TW-1:0]   executionTag;
   logic [$clog2(D):0] occupancy;

   always #5 clk = ~clk;

   broadcast_wakeup_station #(
      .DATA_WIDTH (DW),
      .TAG_WIDTH  (TW),
      .EXEC_WIDTH (EW),
      .RS_DEPTH   (D)
   ) dut (
      .clk                      (clk),
      .rst                      (rst),
      .flush                    (flush),
      .alloc_valid              (alloc_valid),
      .alloc_ready              (alloc_ready),
      .alloc_executionID        (alloc_executionID),
      .alloc_executionTag       (alloc_executionTag),
      .alloc_op1_ready          (alloc_op1_ready),
      .alloc_op1                (alloc_op1),
      .alloc_op2_ready          (alloc_op2_ready),
      .alloc_op2                (alloc_op2),
      .broadcastDataAvailable   (broadcastDataAvailable),
      .broadcastDestinationTag  (broadcastDestinationTag),
      .broadcastDestinationData (broadcastDestinationData),
      .availableFunctionalUnits (availableFunctionalUnits),
      .dispatch                 (dispatch),
      .op1                      (op1),
      .op2                      (op2),
      .executionID              (executionID),
      .executionTag             (executionTag),
      .occupancy                (occupancy)
   );

   typedef struct packed {
      logic [EW-1:0] id;
      logic [TW-1:0] tag;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int unsigned checks = 0;
   int unsigned passed = 0;

   task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
      checks = checks + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic drive_alloc(input logic [EW-1:0] id, input logic [TW-1:0] tag,
                              input logic r1, input logic [DW-1:0] v1,
                              input logic r2, input logic [DW-1:0] v2);
      alloc_valid        = 1'b1;
      alloc_executionID  = id;
      alloc_executionTag = tag;
      alloc_op1_ready    = r1;
      alloc_op1          = v1;
      alloc_op2_ready    = r2;
      alloc_op2          = v2;
   endtask

   task automatic no_alloc();
      alloc_valid = 1'b0;
   endtask

   task automatic bcast(input logic v, input logic [TW-1:0] t, input logic [DW-1:0] d);
      broadcastDataAvailable   = v;
      broadcastDestinationTag  = t;
      broadcastDestinationData = d;
   endtask

   task automatic expect_issue(input logic [EW-1:0] id, input logic [TW-1:0] tag,
                               input logic [DW-1:0] a, input logic [DW-1:0] b);
      sb.push_back('{id: id, tag: tag, a: a, b: b});
   endtask

   // Every issue strobe must match the oldest expected payload.
   always @(negedge clk) begin
      if (!rst && dispatch) begin
         if (sb.size() == 0) begin
            chk("unexpected_dispatch", 128'(dispatch), 128'(0));
         end else begin
            mon_e = sb.pop_front();
            chk("issue_payload", 128'({executionID, executionTag, op1, op2}), 128'(mon_e));
         end
      end
   end

   initial begin
      rst = 1'b1;
      flush = 1'b0;
      alloc_valid = 1'b0;
      alloc_executionID = '0;
      alloc_executionTag = '0;
      alloc_op1_ready = 1'b0;
      alloc_op1 = '0;
      alloc_op2_ready = 1'b0;
      alloc_op2 = '0;
      bcast(1'b0, '0, '0);
      availableFunctionalUnits = '1;
      #1;
      chk("rst_dispatch", 128'(dispatch), 128'(0));
      chk("rst_op1", 128'(op1), 128'(0));
      chk("rst_op2", 128'(op2), 128'(0));
      chk("rst_id", 128'(executionID), 128'(0));
      chk("rst_tag", 128'(executionTag), 128'(0));
      chk("rst_occ", 128'(occupancy), 128'(0));
      chk("rst_alloc_ready", 128'(alloc_ready), 128'(1));
      tick();
      rst = 1'b0;
      tick();

      // ready ADD issues one cycle after the allocation edge
      drive_alloc(FU_ADD, 7'd5, 1'b1, 32'd3, 1'b1, 32'd4);
      expect_issue(FU_ADD, 7'd5, 32'd3, 32'd4);
      tick(); no_alloc();
      chk("t1_occ_alloc", 128'(occupancy), 128'(1));
      chk("t1_no_dispatch_yet", 128'(dispatch), 128'(0));
      tick();
      chk("t1_dispatch", 128'(dispatch), 128'(1));
      chk("t1_occ_issue", 128'(occupancy), 128'(0));
      tick();
      chk("t1_one_cycle", 128'(dispatch), 128'(0));

      // op1 waits on tag 12, woken two cycles after allocation
      drive_alloc(FU_SUB, 7'd6, 1'b0, 32'd12, 1'b1, 32'd1);
      tick(); no_alloc();
      tick();
      chk("t2_waiting", 128'(dispatch), 128'(0));
      bcast(1'b1, 7'd12, 32'h50);
      expect_issue(FU_SUB, 7'd6, 32'h50, 32'd1);
      tick(); bcast(1'b0, '0, '0);
      chk("t2_wake_cycle", 128'(dispatch), 128'(0));
      tick();
      chk("t2_dispatch", 128'(dispatch), 128'(1));
      tick();
      chk("t2_occ", 128'(occupancy), 128'(0));

      // allocate-bypass: op2 tag broadcast in the allocation cycle
      drive_alloc(FU_OR, 7'd7, 1'b1, 32'd9, 1'b0, 32'd20);
      bcast(1'b1, 7'd20, 32'hAA);
      expect_issue(FU_OR, 7'd7, 32'd9, 32'hAA);
      tick(); no_alloc(); bcast(1'b0, '0, '0);
      chk("t3_no_dispatch_yet", 128'(dispatch), 128'(0));
      tick();
      chk("t3_dispatch", 128'(dispatch), 128'(1));
      tick();

      // two XOR entries: back-to-back same FU is masked for one cycle
      availableFunctionalUnits[FU_XOR] = 1'b0;
      drive_alloc(FU_XOR, 7'd1, 1'b1, 32'h11, 1'b1, 32'h12);
      expect_issue(FU_XOR, 7'd1, 32'h11, 32'h12);
      tick();
      drive_alloc(FU_XOR, 7'd2, 1'b1, 32'h21, 1'b1, 32'h22);
      expect_issue(FU_XOR, 7'd2, 32'h21, 32'h22);
      tick(); no_alloc(); availableFunctionalUnits = '1;
      chk("t4_fu_busy", 128'(dispatch), 128'(0));
      chk("t4_occ", 128'(occupancy), 128'(2));
      tick();
      chk("t4_first", 128'(dispatch), 128'(1));
      tick();
      chk("t4_masked", 128'(dispatch), 128'(0));
      tick();
      chk("t4_second", 128'(dispatch), 128'(1));
      tick();
      chk("t4_occ_end", 128'(occupancy), 128'(0));

      // NOP is exempt from the mask and issues back to back
      availableFunctionalUnits[FU_NOP] = 1'b0;
      drive_alloc(FU_NOP, 7'd40, 1'b1, 32'd1, 1'b1, 32'd2);
      expect_issue(FU_NOP, 7'd40, 32'd1, 32'd2);
      tick();
      drive_alloc(FU_NOP, 7'd41, 1'b1, 32'd3, 1'b1, 32'd4);
      expect_issue(FU_NOP, 7'd41, 32'd3, 32'd4);
      tick(); no_alloc(); availableFunctionalUnits = '1;
      tick();
      chk("t4n_first", 128'(dispatch), 128'(1));
      tick();
      chk("t4n_second", 128'(dispatch), 128'(1));
      tick();
      chk("t4n_done", 128'(dispatch), 128'(0));

      // fill all entries waiting on tag 30, drop a 9th, then drain
      for (int i = 0; i < 8; i++) begin
         drive_alloc(4'(i), 7'(50 + i), 1'b0, 32'd30, 1'b1, 32'(i));
         tick();
      end
      chk("t5_full_ready", 128'(alloc_ready), 128'(0));
      chk("t5_full_occ", 128'(occupancy), 128'(8));
      drive_alloc(FU_ADD, 7'd99, 1'b1, 32'd1, 1'b1, 32'd1);
      tick(); no_alloc();
      chk("t5_dropped_occ", 128'(occupancy), 128'(8));
      chk("t5_no_dispatch", 128'(dispatch), 128'(0));
      bcast(1'b1, 7'd30, 32'h30);
      for (int i = 0; i < 8; i++) expect_issue(4'(i), 7'(50 + i), 32'h30, 32'(i));
      tick(); bcast(1'b0, '0, '0);
      chk("t5_wake_cycle", 128'(dispatch), 128'(0));
      chk("t5_still_full", 128'(alloc_ready), 128'(0));
      tick();
      chk("t5_first_issue", 128'(dispatch), 128'(1));
      chk("t5_room", 128'(alloc_ready), 128'(1));
      chk("t5_occ7", 128'(occupancy), 128'(7));
      for (int k = 1; k < 8; k++) begin
         tick();
         chk($sformatf("t5_issue_%0d", k), 128'(dispatch), 128'(1));
      end
      tick();
      chk("t5_drained", 128'(dispatch), 128'(0));
      chk("t5_occ0", 128'(occupancy), 128'(0));

      // flush with an eligible entry and a competing allocation
      drive_alloc(FU_AND, 7'd80, 1'b0, 32'd31, 1'b1, 32'd0);
      tick();
      drive_alloc(FU_OR, 7'd81, 1'b0, 32'd31, 1'b1, 32'd0);
      tick();
      drive_alloc(FU_ADD, 7'd82, 1'b1, 32'd5, 1'b1, 32'd6);
      tick();
      flush = 1'b1;
      drive_alloc(FU_ADD, 7'd83, 1'b1, 32'd7, 1'b1, 32'd8);
      chk("t6_occ_pre", 128'(occupancy), 128'(3));
      tick(); flush = 1'b0; no_alloc();
      chk("t6_no_dispatch", 128'(dispatch), 128'(0));
      chk("t6_occ_flushed", 128'(occupancy), 128'(0));
      bcast(1'b1, 7'd31, 32'h77);
      tick(); bcast(1'b0, '0, '0);
      chk("t6_bcast_empty", 128'(dispatch), 128'(0));
      tick();
      chk("t6_still_none", 128'(dispatch), 128'(0));
      chk("t6_occ_end", 128'(occupancy), 128'(0));

      // asynchronous reset pulse between clock edges
      drive_alloc(FU_SRA, 7'd90, 1'b0, 32'd33, 1'b1, 32'd0);
      tick();
      drive_alloc(FU_ADD, 7'd91, 1'b1, 32'hDEAD, 1'b1, 32'hBEEF);
      expect_issue(FU_ADD, 7'd91, 32'hDEAD, 32'hBEEF);
      tick(); no_alloc();
      tick();
      chk("t7_dispatch", 128'(dispatch), 128'(1));
      chk("t7_occ", 128'(occupancy), 128'(1));
      #2 rst = 1'b1;
      #1;
      chk("t7_rst_dispatch", 128'(dispatch), 128'(0));
      chk("t7_rst_op1", 128'(op1), 128'(0));
      chk("t7_rst_op2", 128'(op2), 128'(0));
      chk("t7_rst_id", 128'(executionID), 128'(0));
      chk("t7_rst_tag", 128'(executionTag), 128'(0));
      chk("t7_rst_occ", 128'(occupancy), 128'(0));
      chk("t7_rst_ready", 128'(alloc_ready), 128'(1));
      tick(); rst = 1'b0;
      bcast(1'b1, 7'd33, 32'h99);
      tick(); bcast(1'b0, '0, '0);
      chk("t7_lost_entry", 128'(dispatch), 128'(0));
      tick();
      chk("t7_lost_entry2", 128'(dispatch), 128'(0));
      chk("t7_occ_end", 128'(occupancy), 128'(0));

      chk("scoreboard_drained", 128'(sb.size()), 128'(0));
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
